// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the Y86-64 memory stage and
// the data memory. The memory stage is the master and the memory is the slave.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata, dmem_err
  );
endinterface

// File: rtl/mem_stage.sv
// Y86-64 memory stage: takes execute results, performs at most one data
// memory access over the req/ack bus, and emits the M->W writeback bundle.
// Optional build macro MEM_TIMEOUT_EN: abandon an access that is not
// acknowledged within TIMEOUT cycles and report it as an address fault.
//
// state  | meaning
// IDLE   | accepting execute results; no access outstanding
// ACCESS | request on the bus, waiting for dmem_ack
// HALT   | HLT/ADR/INS was emitted; stalled until reset
module mem_stage #(
  parameter logic [63:0] ADDR_MAX = 64'h0000_0000_0000_1FFF
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic [2:0]  e_stat,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic        m_stall,
  mem_stage_if.master dmem,
  output logic        w_valid,
  output logic [3:0]  w_icode,
  output logic [2:0]  w_stat,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HALT} state_t;

  state_t      r_state, w_nxt_state;
  logic        r_req, w_nxt_req;
  logic        r_we, w_nxt_we;
  logic [63:0] r_addr, w_nxt_addr;
  logic [63:0] r_wdata, w_nxt_wdata;
  // Fields of the instruction whose access is outstanding.
  logic        r_p_rd, w_nxt_p_rd;
  logic [3:0]  r_p_icode, w_nxt_p_icode;
  logic [63:0] r_p_valE, w_nxt_p_valE;
  logic [3:0]  r_p_dstE, w_nxt_p_dstE;
  logic [3:0]  r_p_dstM, w_nxt_p_dstM;
  // Writeback bundle.
  logic        r_w_valid, w_nxt_w_valid;
  logic [3:0]  r_w_icode, w_nxt_w_icode;
  logic [2:0]  r_w_stat, w_nxt_w_stat;
  logic [63:0] r_w_valE, w_nxt_w_valE;
  logic [63:0] r_w_valM, w_nxt_w_valM;
  logic [3:0]  r_w_dstE, w_nxt_w_dstE;
  logic [3:0]  r_w_dstM, w_nxt_w_dstM;
`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_cnt, w_nxt_cnt;
`endif

  logic        w_is_wr, w_is_rd, w_acc;
  logic [63:0] w_addr;
  logic [3:0]  w_dstE_eff;

  // Access decode: ret/popq address through valA, everything else through valE.
  always_comb begin
    w_is_wr    = (e_icode == 4'h4) || (e_icode == 4'h8) || (e_icode == 4'hA);
    w_is_rd    = (e_icode == 4'h5) || (e_icode == 4'h9) || (e_icode == 4'hB);
    w_acc      = w_is_wr || w_is_rd;
    w_addr     = ((e_icode == 4'h9) || (e_icode == 4'hB)) ? e_valA : e_valE;
    w_dstE_eff = ((e_icode == 4'h2) && !e_Cnd) ? REG_NONE : e_dstE;
  end

  // Next-state and next-register logic; everything holds unless changed.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_req     = r_req;
    w_nxt_we      = r_we;
    w_nxt_addr    = r_addr;
    w_nxt_wdata   = r_wdata;
    w_nxt_p_rd    = r_p_rd;
    w_nxt_p_icode = r_p_icode;
    w_nxt_p_valE  = r_p_valE;
    w_nxt_p_dstE  = r_p_dstE;
    w_nxt_p_dstM  = r_p_dstM;
    w_nxt_w_valid = 1'b0;
    w_nxt_w_icode = r_w_icode;
    w_nxt_w_stat  = r_w_stat;
    w_nxt_w_valE  = r_w_valE;
    w_nxt_w_valM  = r_w_valM;
    w_nxt_w_dstE  = r_w_dstE;
    w_nxt_w_dstM  = r_w_dstM;
`ifdef MEM_TIMEOUT_EN
    w_nxt_cnt     = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (e_valid) begin
          if ((e_stat != STAT_AOK) || !w_acc || (w_addr > ADDR_MAX)) begin
            // Completes in one cycle with no bus activity.
            w_nxt_w_valid = 1'b1;
            w_nxt_w_icode = e_icode;
            w_nxt_w_stat  = (e_stat != STAT_AOK) ? e_stat :
                            (w_acc ? STAT_ADR : STAT_AOK);
            w_nxt_w_valE  = e_valE;
            w_nxt_w_valM  = 64'd0;
            w_nxt_w_dstE  = w_dstE_eff;
            w_nxt_w_dstM  = e_dstM;
            w_nxt_state   = (w_nxt_w_stat != STAT_AOK) ? S_HALT : S_IDLE;
          end else begin
            w_nxt_req     = 1'b1;
            w_nxt_we      = w_is_wr;
            w_nxt_addr    = w_addr;
            w_nxt_wdata   = e_valA;
            w_nxt_p_rd    = w_is_rd;
            w_nxt_p_icode = e_icode;
            w_nxt_p_valE  = e_valE;
            w_nxt_p_dstE  = w_dstE_eff;
            w_nxt_p_dstM  = e_dstM;
            w_nxt_state   = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
            w_nxt_cnt     = 16'd0;
`endif
          end
        end
      end
      S_ACCESS: begin
        if (dmem.dmem_ack) begin
          w_nxt_req     = 1'b0;
          w_nxt_w_valid = 1'b1;
          w_nxt_w_icode = r_p_icode;
          w_nxt_w_stat  = dmem.dmem_err ? STAT_ADR : STAT_AOK;
          w_nxt_w_valE  = r_p_valE;
          w_nxt_w_valM  = r_p_rd ? dmem.dmem_rdata : 64'd0;
          w_nxt_w_dstE  = r_p_dstE;
          w_nxt_w_dstM  = r_p_dstM;
          w_nxt_state   = dmem.dmem_err ? S_HALT : S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_nxt_req     = 1'b0;
          w_nxt_w_valid = 1'b1;
          w_nxt_w_icode = r_p_icode;
          w_nxt_w_stat  = STAT_ADR;
          w_nxt_w_valE  = r_p_valE;
          w_nxt_w_valM  = 64'd0;
          w_nxt_w_dstE  = r_p_dstE;
          w_nxt_w_dstM  = r_p_dstM;
          w_nxt_state   = S_HALT;
        end else begin
          w_nxt_cnt = r_cnt + 16'd1;
        end
`endif
      end
      default: ;
    endcase
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 64'd0;
      r_wdata   <= 64'd0;
      r_p_rd    <= 1'b0;
      r_p_icode <= 4'd0;
      r_p_valE  <= 64'd0;
      r_p_dstE  <= REG_NONE;
      r_p_dstM  <= REG_NONE;
      r_w_valid <= 1'b0;
      r_w_icode <= 4'h1;
      r_w_stat  <= STAT_AOK;
      r_w_valE  <= 64'd0;
      r_w_valM  <= 64'd0;
      r_w_dstE  <= REG_NONE;
      r_w_dstM  <= REG_NONE;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= 16'd0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_req     <= w_nxt_req;
      r_we      <= w_nxt_we;
      r_addr    <= w_nxt_addr;
      r_wdata   <= w_nxt_wdata;
      r_p_rd    <= w_nxt_p_rd;
      r_p_icode <= w_nxt_p_icode;
      r_p_valE  <= w_nxt_p_valE;
      r_p_dstE  <= w_nxt_p_dstE;
      r_p_dstM  <= w_nxt_p_dstM;
      r_w_valid <= w_nxt_w_valid;
      r_w_icode <= w_nxt_w_icode;
      r_w_stat  <= w_nxt_w_stat;
      r_w_valE  <= w_nxt_w_valE;
      r_w_valM  <= w_nxt_w_valM;
      r_w_dstE  <= w_nxt_w_dstE;
      r_w_dstM  <= w_nxt_w_dstM;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= w_nxt_cnt;
`endif
    end
  end

  assign m_stall         = (r_state == S_ACCESS) || (r_state == S_HALT);
  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign w_valid         = r_w_valid;
  assign w_icode         = r_w_icode;
  assign w_stat          = r_w_stat;
  assign w_valE          = r_w_valE;
  assign w_valM          = r_w_valM;
  assign w_dstE          = r_w_dstE;
  assign w_dstM          = r_w_dstM;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs
// are checked on the following falling edge after the DUT's rising edge.
module tb_mem_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [2:0]  e_stat;
  logic        e_Cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  e_dstE, e_dstM;
  logic        m_stall;
  logic        w_valid;
  logic [3:0]  w_icode;
  logic [2:0]  w_stat;
  logic [63:0] w_valE, w_valM;
  logic [3:0]  w_dstE, w_dstM;

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt;
  int req_cnt;

  mem_stage_if dmem ();

  mem_stage dut (
    .clock(clock), .reset(reset),
    .e_valid(e_valid), .e_icode(e_icode), .e_stat(e_stat), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .m_stall(m_stall), .dmem(dmem),
    .w_valid(w_valid), .w_icode(w_icode), .w_stat(w_stat),
    .w_valE(w_valE), .w_valM(w_valM), .w_dstE(w_dstE), .w_dstM(w_dstM)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] icode, input logic [2:0] stat, input logic cnd,
                       input logic [63:0] vale, input logic [63:0] vala,
                       input logic [3:0] dste, input logic [3:0] dstm);
    e_valid = 1'b1;
    e_icode = icode;
    e_stat  = stat;
    e_Cnd   = cnd;
    e_valE  = vale;
    e_valA  = vala;
    e_dstE  = dste;
    e_dstM  = dstm;
  endtask

  task automatic idle_in();
    e_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    e_valid = 1'b0; e_icode = 4'h0; e_stat = 3'd1; e_Cnd = 1'b0;
    e_valE = 64'd0; e_valA = 64'd0; e_dstE = 4'hF; e_dstM = 4'hF;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 64'd0; dmem.dmem_err = 1'b0;
    @(negedge clock);
    step();

    check("rst_w_valid", w_valid, 0);
    check("rst_w_icode", w_icode, 1);
    check("rst_w_stat",  w_stat, 1);
    check("rst_w_dstE",  w_dstE, 4'hF);
    check("rst_w_dstM",  w_dstM, 4'hF);
    check("rst_w_valM",  w_valM, 0);
    check("rst_m_stall", m_stall, 0);
    check("rst_req",     dmem.dmem_req, 0);
    reset = 1'b0;

    // opq: no access, latency 1
    drive(4'h6, 3'd1, 1'b0, 64'h5, 64'h0, 4'h3, 4'hF);
    step(); idle_in();
    check("opq_w_valid", w_valid, 1);
    check("opq_w_valE",  w_valE, 64'h5);
    check("opq_w_dstE",  w_dstE, 4'h3);
    check("opq_w_stat",  w_stat, 1);
    check("opq_w_valM",  w_valM, 0);
    check("opq_req",     dmem.dmem_req, 0);
    check("opq_stall",   m_stall, 0);
    step();
    check("opq_pulse_end", w_valid, 0);
    check("opq_hold_valE", w_valE, 64'h5);

    // cmov not taken / taken
    drive(4'h2, 3'd1, 1'b0, 64'h9, 64'h0, 4'h5, 4'hF);
    step(); idle_in();
    check("cmov0_w_valid", w_valid, 1);
    check("cmov0_w_dstE",  w_dstE, 4'hF);
    check("cmov0_w_valE",  w_valE, 64'h9);
    drive(4'h2, 3'd1, 1'b1, 64'h9, 64'h0, 4'h5, 4'hF);
    step(); idle_in();
    check("cmov1_w_dstE", w_dstE, 4'h5);

    // mrmovq with ack in the fourth request cycle
    drive(4'h5, 3'd1, 1'b0, 64'h100, 64'h0, 4'hF, 4'h2);
    step(); idle_in();
    check("ld_req",  dmem.dmem_req, 1);
    check("ld_we",   dmem.dmem_we, 0);
    check("ld_addr", dmem.dmem_addr, 64'h100);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_stall) stall_cnt++;
      step();
    end
    check("ld_req_held",  dmem.dmem_req, 1);
    check("ld_addr_held", dmem.dmem_addr, 64'h100);
    if (m_stall) stall_cnt++;
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hDEAD;
    step();
    dmem.dmem_ack = 1'b0;
    check("ld_w_valid",   w_valid, 1);
    check("ld_w_valM",    w_valM, 64'hDEAD);
    check("ld_w_dstM",    w_dstM, 4'h2);
    check("ld_w_icode",   w_icode, 4'h5);
    check("ld_w_stat",    w_stat, 1);
    check("ld_req_drop",  dmem.dmem_req, 0);
    check("ld_stall_end", m_stall, 0);
    check("ld_stall_cnt", 64'(stall_cnt), 4);

    // stray ack in IDLE is ignored
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    check("stray_w_valid", w_valid, 0);
    check("stray_req",     dmem.dmem_req, 0);
    check("stray_stall",   m_stall, 0);

    // rmmovq with ack in the first request cycle
    drive(4'h4, 3'd1, 1'b0, 64'h200, 64'h77, 4'hF, 4'hF);
    step(); idle_in();
    check("st_req",     dmem.dmem_req, 1);
    check("st_we",      dmem.dmem_we, 1);
    check("st_wdata",   dmem.dmem_wdata, 64'h77);
    check("st_addr",    dmem.dmem_addr, 64'h200);
    check("st_w_valid0", w_valid, 0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'h1234;
    step();
    dmem.dmem_ack = 1'b0;
    check("st_w_valid", w_valid, 1);
    check("st_w_valM",  w_valM, 0);
    check("st_req_drop", dmem.dmem_req, 0);

    // ret reads through valA; reset while ACCESS abandons it
    drive(4'h9, 3'd1, 1'b0, 64'h10, 64'h1000, 4'h4, 4'hF);
    step(); idle_in();
    check("ret_req",  dmem.dmem_req, 1);
    check("ret_we",   dmem.dmem_we, 0);
    check("ret_addr", dmem.dmem_addr, 64'h1000);
    do_reset();
    check("rstacc_req",     dmem.dmem_req, 0);
    check("rstacc_w_valid", w_valid, 0);
    check("rstacc_stall",   m_stall, 0);
    step();
    check("rstacc_w_valid2", w_valid, 0);

    // address exactly ADDR_MAX is legal; error response halts
    drive(4'h5, 3'd1, 1'b0, 64'h1FFF, 64'h0, 4'hF, 4'h6);
    step(); idle_in();
    check("max_req",  dmem.dmem_req, 1);
    check("max_addr", dmem.dmem_addr, 64'h1FFF);
    dmem.dmem_ack = 1'b1; dmem.dmem_err = 1'b1; dmem.dmem_rdata = 64'h0;
    step();
    dmem.dmem_ack = 1'b0; dmem.dmem_err = 1'b0;
    check("err_w_valid", w_valid, 1);
    check("err_w_stat",  w_stat, 3);
    check("err_stall",   m_stall, 1);
    do_reset();

    // popq beyond ADDR_MAX: no request, ADR, then HALT
    drive(4'hB, 3'd1, 1'b0, 64'h8, 64'h2000, 4'h4, 4'h3);
    step(); idle_in();
    check("pop_w_valid", w_valid, 1);
    check("pop_w_stat",  w_stat, 3);
    check("pop_w_icode", w_icode, 4'hB);
    check("pop_req",     dmem.dmem_req, 0);
    check("pop_stall",   m_stall, 1);
    drive(4'h6, 3'd1, 1'b0, 64'h7, 64'h0, 4'h1, 4'hF);
    step(); idle_in();
    check("halt_w_valid", w_valid, 0);
    check("halt_stall",   m_stall, 1);
    check("halt_valE",    w_valE, 64'h8);
    step();
    check("halt_stall2", m_stall, 1);
    check("halt_req",    dmem.dmem_req, 0);
    do_reset();
    check("halt_cleared", m_stall, 0);

    // INS on an access icode: no request, status passes through, HALT
    drive(4'h5, 3'd4, 1'b0, 64'h40, 64'h0, 4'hF, 4'h2);
    step(); idle_in();
    check("ins_w_valid", w_valid, 1);
    check("ins_w_stat",  w_stat, 4);
    check("ins_req",     dmem.dmem_req, 0);
    check("ins_stall",   m_stall, 1);
    check("ins_w_valM",  w_valM, 0);
    do_reset();

    // pushq: write at valE with data valA
    drive(4'hA, 3'd1, 1'b0, 64'h300, 64'h55, 4'h4, 4'hF);
    step(); idle_in();
    check("push_req",   dmem.dmem_req, 1);
    check("push_we",    dmem.dmem_we, 1);
    check("push_addr",  dmem.dmem_addr, 64'h300);
    check("push_wdata", dmem.dmem_wdata, 64'h55);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hBEEF;
    step();
    dmem.dmem_ack = 1'b0;
    check("push_w_valid", w_valid, 1);
    check("push_w_valM",  w_valM, 0);
    check("push_w_dstE",  w_dstE, 4'h4);

`ifdef MEM_TIMEOUT_EN
    // ack withheld: request lasts TIMEOUT cycles then ADR and HALT
    drive(4'h5, 3'd1, 1'b0, 64'h50, 64'h0, 4'hF, 4'h2);
    step(); idle_in();
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dmem.dmem_req) break;
      req_cnt++;
      step();
    end
    check("tmo_req_cycles", 64'(req_cnt), 16);
    check("tmo_w_valid",    w_valid, 1);
    check("tmo_w_stat",     w_stat, 3);
    check("tmo_stall",      m_stall, 1);
    do_reset();
`else
    req_cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Y86-64 memory stage. Consumes the execute stage's results (valE, valA, Cnd, destinations, status) and performs any data-memory read or write through a req/ack handshake. Drives the M->W pipeline outputs. Back-pressures execute while an access is outstanding or after a fault/halt.

Parameters:
ADDR_MAX, 64'h0000_0000_0000_1FFF, highest legal byte address; a larger address raises SADR with no request issued
TIMEOUT, 16, cycles to wait for dmem_ack (only with MEM_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
e_valid  in  1  execute result valid this cycle
e_icode  in  4  instruction code
e_stat  in  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
e_Cnd  in  1  condition outcome from execute
e_valE  in  64  ALU result / effective address
e_valA  in  64  store data or stack address
e_dstE  in  4  ALU destination register (4'hF = none)
e_dstM  in  4  load destination register (4'hF = none)
m_stall  out  1  execute must hold its outputs
dmem_req  out  1  access request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  64  byte address
dmem_wdata  out  64  store data
dmem_ack  in  1  access complete
dmem_rdata  in  64  load data, valid with ack
dmem_err  in  1  access fault, valid with ack
w_valid  out  1  one-cycle pulse: writeback bundle valid
w_icode, w_stat, w_valE, w_valM, w_dstE, w_dstM  out  4,3,64,64,4,4  writeback bundle

Behaviour:
- States: IDLE, ACCESS, HALT. Reset -> IDLE. All outputs 0 except the following: w_icode=1 (nop), w_stat=1, w_dstE=w_dstM=4'hF. The w_* bundle holds its value when w_valid=0.
- m_stall = (state==ACCESS)|(state==HALT), combinational. Inputs are sampled only in IDLE with e_valid=1.
- Access decode: icodes 4 rmmovq and 8 call write addr=valE; icode A pushq writes addr=valE; in all three wdata=valA. Icode 5 mrmovq reads addr=valE. Icodes 9 ret and B popq read addr=valA. All other icodes make no access.
- cmovXX (icode 2) with e_Cnd=0: w_dstE forced to 4'hF.
- No access, or e_stat!=AOK: w_valid=1 at the next edge (latency 1). w_valM=0. No request issued.
- Access with addr>ADDR_MAX: no request issued. Latency 1 with w_stat=3.
- Legal access: at the sampling edge, dmem_req=1 and dmem_we/addr/wdata are registered; state goes to ACCESS. The request fields stay stable until the edge where dmem_ack=1 is sampled.
- At that edge: dmem_req=0, w_valid=1, w_valM=dmem_rdata (reads only; writes give 0). w_stat=3 if dmem_err else e_stat. State -> IDLE. Minimum load/store latency is 2 cycles (ack in the first req cycle).
- Any emitted w_stat!=1 (HLT, ADR, INS) -> HALT. HALT: no requests, w_valid=0, m_stall=1, left only by reset.
- Reset in ACCESS: dmem_req drops at that edge and the transaction is abandoned, with no w_valid.
- dmem_ack while dmem_req=0 is ignored.

Optional Feature:
MEM_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. On reaching TIMEOUT cycles, the block drops req, emits w_valid with w_stat=3, and goes to HALT. MEM_TIMEOUT_EN undefined: no counter, and ACCESS waits indefinitely.

Test Plan:
- opq (icode 6), valE=64'h5, dstE=3 -> next cycle w_valid=1, w_valE=5, w_dstE=3, w_stat=1, dmem_req never asserted.
- mrmovq valE=64'h100, dstM=2, ack after 3 cycles with rdata=64'hDEAD -> m_stall=1 for 4 cycles, dmem_we=0, addr=64'h100, then w_valM=64'hDEAD, w_dstM=2.
- rmmovq valE=64'h200, valA=64'h77, ack in first cycle -> dmem_we=1, wdata=64'h77, w_valid 2 cycles after sample, w_valM=0.
- popq valA=64'h2000 (>ADDR_MAX) -> no req, w_stat=3, then m_stall=1 permanently; a later e_valid produces no output until reset.
- cmov with e_Cnd=0, dstE=5 -> w_dstE=4'hF. Separately, reset asserted mid-ACCESS -> dmem_req=0 and w_valid=0 next cycle, state IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT=16, ack withheld -> req dropped after 16 cycles, w_stat=3, HALT.
